mcpu_ctrl_fsm: RTL
==================

# mcpu_ctrl_fsm

Multi-cycle MIPS control unit: a Moore state machine that sequences the shared multi-cycle datapath (single memory port, IR, A/B, ALUOut, MDR registers) one micro-step per clock. It replaces the single-cycle controller when the CPU is built as a multi-cycle core. It keeps the same opcode/funct coverage and the same ALU_Control encoding, and it stalls on the memory-ready handshake.

## Interface
- No parameters; state encoding fixed below.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- OPcode  in  6  IR[31:26]; valid from ID onward.
- Fun  in  6  IR[5:0].
- zero  in  1  ALU zero flag, combinational in the current cycle.
- MIO_ready  in  1  memory/IO transfer complete this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, CPU_MIO  out  1 each.
- ALUSrcB  out  2  00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2.
- RegDst  out  2  00=rt, 01=rd, 10=$31.
- MemtoReg  out  2  00=ALUOut, 01=MDR, 10=imm<<16 (lui), 11=PC.
- PCSource  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target, 11=rs (A).
- Branch_ne  out  1  invert zero for the conditional PC write.
- ALU_Control  out  3  and=000, or=001, add=010, xor=011, nor=100, srl=101, sub=110, slt=111.
- state  out  5  current state, for debug display.
- illegal  out  1  one-cycle pulse on an undecodable instruction.

## Operation
- States: IF=0, ID=1, MA=2, MRD=3, LWB=4, MWR=5, REX=6, RWB=7, IEX=8, IWB=9, BR=10, J=11, JAL=12, JR=13, JALR=14. Codes 15–31 are unreachable; if ever entered, the next state is IF.
- Any output not listed for a state is 0.
- IF: MemRead, CPU_MIO; ALUSrcA=0, ALUSrcB=01, add; PCSource=00.
  - IRWrite and PCWrite are asserted only when MIO_ready=1, which also advances to ID. Otherwise the FSM holds in IF.
- ID: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Next state by opcode:
  - lw/sw (100011/101011) -> MA.
  - R-type (000000): add/sub/and/or/xor/nor/slt/srl -> REX; jr (001000) -> JR; jalr (001001) -> JALR.
  - addi/andi/ori/xori/lui/slti -> IEX.
  - beq/bne -> BR; j -> J; jal -> JAL.
  - Anything else -> IF with illegal=1 for that cycle.
- MA: ALUSrcA=1, ALUSrcB=10, add. Next is MRD for lw, MWR for sw.
- MRD: IorD, MemRead, CPU_MIO. Moves to LWB on MIO_ready, else holds.
- LWB: RegDst=00, MemtoReg=01, RegWrite. Next IF.
- MWR: IorD, MemWrite, CPU_MIO. Moves to IF on MIO_ready, else holds with MemWrite kept high.
- REX: ALUSrcA=1, ALUSrcB=00, ALU_Control from Fun. Next RWB.
- RWB: RegDst=01, MemtoReg=00, RegWrite. Next IF.
- IEX: ALUSrcA=1, ALUSrcB=10, ALU op: addi=add, andi=and, ori=or, xori=xor, slti=slt, lui=add. Next IWB.
- IWB: RegDst=00, RegWrite; MemtoReg=10 for lui, else 00. Next IF.
- BR: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond, PCSource=01; Branch_ne=1 for bne. Next IF.
- J: PCWrite, PCSource=10. JAL adds RegDst=10, MemtoReg=11, RegWrite.
- JR: PCWrite, PCSource=11. JALR adds RegDst=01, MemtoReg=11, RegWrite.
- The RegWrite of PC in JAL/JALR sees the already-incremented PC (PC+4).

## Timing
- State register updates on the rising edge of clk. rst_n low forces state=IF asynchronously.
- While rst_n is low, every output is 0, including the MemRead/CPU_MIO that IF would normally drive. Outputs are the combinational Moore decode of state, gated by rst_n, plus the MIO_ready gating in IF.
- Cycles per instruction with MIO_ready tied to 1: lw 5; sw, R-type, I-type 4; beq/bne, j, jal, jr, jalr 3; illegal 2.
- Each cycle MIO_ready is low in IF, MRD or MWR adds exactly one cycle. No write strobe is ever issued twice.
- If reset asserts mid-instruction, the FSM returns to IF immediately. No partial register or memory write completes after rst_n falls.

## Test plan
- Reset with rst_n=0 for 3 cycles: all outputs 0 and state=0. After release, state goes 0->1 on the first edge with MIO_ready=1.
- add (OPcode 000000, Fun 100000) with MIO_ready=1: states 0,1,6,7,0. ALU_Control=010 in REX. RegDst=01 and RegWrite=1 only in RWB.
- lw with MIO_ready low for 2 cycles in MRD: states 0,1,2,3,3,3,4,0. MemtoReg=01 and RegWrite=1 only in LWB.
- bne with zero=0, then beq with zero=0: both go 0,1,10,0. Branch_ne=1 on bne only, PCWriteCond=1 in BR for both.
- jal: states 0,1,12,0 with PCSource=10, RegDst=10, MemtoReg=11, RegWrite=1. jr follows 0,1,13 with PCSource=11.
- OPcode 111111: states 0,1,0 with illegal=1 for exactly the ID cycle. Also assert rst_n low during MWR: MemWrite drops the same cycle and state=0.

Source files
------------

// File: rtl/mcpu_ctrl_fsm_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// Carries the instruction fields, status flags and every datapath strobe.
// master = controller side, slave = datapath side.
interface mcpu_ctrl_fsm_if;
  logic [5:0] OPcode;
  logic [5:0] Fun;
  logic       zero;
  logic       MIO_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ALUSrcA;
  logic       CPU_MIO;
  logic [1:0] ALUSrcB;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] PCSource;
  logic       Branch_ne;
  logic [2:0] ALU_Control;
  logic [4:0] state;
  logic       illegal;

  modport master (
    input  OPcode, Fun, zero, MIO_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           ALUSrcA, CPU_MIO, ALUSrcB, RegDst, MemtoReg, PCSource, Branch_ne,
           ALU_Control, state, illegal
  );

  modport slave (
    output OPcode, Fun, zero, MIO_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           ALUSrcA, CPU_MIO, ALUSrcB, RegDst, MemtoReg, PCSource, Branch_ne,
           ALU_Control, state, illegal
  );
endinterface

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing one datapath micro-step per clock.
// Latency: 2-5 cycles per instruction (illegal 2, lw 5) plus one per memory wait cycle.
// Backpressure: holds in IF/MRD/MWR while MIO_ready is low; strobes stay steady, never re-issued.
module mcpu_ctrl_fsm (
  input  logic           clk,
  input  logic           rst_n,
  mcpu_ctrl_fsm_if.master bus
);

  typedef enum logic [4:0] {
    S_IF   = 5'd0,  S_ID   = 5'd1,  S_MA  = 5'd2,  S_MRD = 5'd3,
    S_LWB  = 5'd4,  S_MWR  = 5'd5,  S_REX = 5'd6,  S_RWB = 5'd7,
    S_IEX  = 5'd8,  S_IWB  = 5'd9,  S_BR  = 5'd10, S_J   = 5'd11,
    S_JAL  = 5'd12, S_JR   = 5'd13, S_JALR = 5'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW   = 6'b100011, OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110, OP_LUI  = 6'b001111, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010, OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101, FN_XOR = 6'b100110, FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010, FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000, FN_JALR = 6'b001001;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010, ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100, ALU_SRL = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  state_t state_q, state_d;

  // R-type funct to ALU operation; only decodable functs ever reach REX.
  function automatic logic [2:0] fun_alu(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_XOR:  return ALU_XOR;
      FN_NOR:  return ALU_NOR;
      FN_SLT:  return ALU_SLT;
      FN_SRL:  return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

  // I-type opcode to ALU operation; lui passes through an add.
  function automatic logic [2:0] imm_alu(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_XORI: return ALU_XOR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // State register; reset returns to instruction fetch immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  assign bus.state = state_q;

  // Next-state and Moore output decode; everything is forced low while in reset.
  always_comb begin
    state_d         = S_IF;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.CPU_MIO     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.RegDst      = 2'b00;
    bus.MemtoReg    = 2'b00;
    bus.PCSource    = 2'b00;
    bus.Branch_ne   = 1'b0;
    bus.ALU_Control = 3'b000;
    bus.illegal     = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          bus.MemRead     = 1'b1;
          bus.CPU_MIO     = 1'b1;
          bus.ALUSrcB     = 2'b01;
          bus.ALU_Control = ALU_ADD;
          bus.IRWrite     = bus.MIO_ready;
          bus.PCWrite     = bus.MIO_ready;
          state_d         = bus.MIO_ready ? S_ID : S_IF;
        end
        S_ID: begin
          bus.ALUSrcB     = 2'b11;
          bus.ALU_Control = ALU_ADD;
          case (bus.OPcode)
            OP_LW, OP_SW: state_d = S_MA;
            OP_RTYPE: begin
              case (bus.Fun)
                FN_ADD, FN_SUB, FN_AND, FN_OR,
                FN_XOR, FN_NOR, FN_SLT, FN_SRL: state_d = S_REX;
                FN_JR:   state_d = S_JR;
                FN_JALR: state_d = S_JALR;
                default: bus.illegal = 1'b1;
              endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI,
            OP_XORI, OP_LUI, OP_SLTI: state_d = S_IEX;
            OP_BEQ, OP_BNE: state_d = S_BR;
            OP_J:    state_d = S_J;
            OP_JAL:  state_d = S_JAL;
            default: bus.illegal = 1'b1;
          endcase
        end
        S_MA: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUSrcB     = 2'b10;
          bus.ALU_Control = ALU_ADD;
          state_d         = (bus.OPcode == OP_SW) ? S_MWR : S_MRD;
        end
        S_MRD: begin
          bus.IorD    = 1'b1;
          bus.MemRead = 1'b1;
          bus.CPU_MIO = 1'b1;
          state_d     = bus.MIO_ready ? S_LWB : S_MRD;
        end
        S_LWB: begin
          bus.MemtoReg = 2'b01;
          bus.RegWrite = 1'b1;
        end
        S_MWR: begin
          bus.IorD     = 1'b1;
          bus.MemWrite = 1'b1;
          bus.CPU_MIO  = 1'b1;
          state_d      = bus.MIO_ready ? S_IF : S_MWR;
        end
        S_REX: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALU_Control = fun_alu(bus.Fun);
          state_d         = S_RWB;
        end
        S_RWB: begin
          bus.RegDst   = 2'b01;
          bus.RegWrite = 1'b1;
        end
        S_IEX: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUSrcB     = 2'b10;
          bus.ALU_Control = imm_alu(bus.OPcode);
          state_d         = S_IWB;
        end
        S_IWB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = (bus.OPcode == OP_LUI) ? 2'b10 : 2'b00;
        end
        S_BR: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALU_Control = ALU_SUB;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'b01;
          bus.Branch_ne   = (bus.OPcode == OP_BNE);
        end
        S_J, S_JAL: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'b10;
          if (state_q == S_JAL) begin
            bus.RegDst   = 2'b10;
            bus.MemtoReg = 2'b11;
            bus.RegWrite = 1'b1;
          end
        end
        S_JR, S_JALR: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'b11;
          if (state_q == S_JALR) begin
            bus.RegDst   = 2'b01;
            bus.MemtoReg = 2'b11;
            bus.RegWrite = 1'b1;
          end
        end
        default: state_d = S_IF;
      endcase
    end
  end

endmodule
